// File: rtl/rrv64_victim_buf_pkg.sv
// rrv64_victim_buf_pkg: shared entry type, drain FSM states and width defaults for the L1 victim buffer
package rrv64_victim_buf_pkg;
  localparam int PADDR_W_DEF = 56;
  localparam int LINE_W_DEF = 512;
  typedef struct packed {
    logic [PADDR_W_DEF-1:0] addr;
    logic [LINE_W_DEF-1:0]  data;
    logic                   dirty;
  } vb_entry_t;
  typedef enum logic [1:0] {IDLE, DRAIN, DONE} vb_state_e;
endpackage

// File: rtl/rrv64_victim_buf_mem.sv
// rrv64_victim_buf_mem: DEPTH-entry victim line storage, one write and one read port, valid bits; entry view exported under RRV64_VICTIM_FWD_EN
module rrv64_victim_buf_mem
  import rrv64_victim_buf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  vb_entry_t                wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output vb_entry_t                rdata,
  output logic [DEPTH-1:0]         vld
`ifdef RRV64_VICTIM_FWD_EN
  ,
  output vb_entry_t                ents [DEPTH]
`endif
);
  vb_entry_t mem_q [DEPTH];
  // line storage is never reset; the valid bits alone qualify it
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end
  // valid bits: cleared on dequeue, set on enqueue
  always_ff @(posedge clk) begin
    if (rst) vld <= '0;
    else begin
      if (re) vld[raddr] <= 1'b0;
      if (we) vld[waddr] <= 1'b1;
    end
  end
  assign rdata = mem_q[raddr];
`ifdef RRV64_VICTIM_FWD_EN
  assign ents = mem_q;
`endif
endmodule

// File: rtl/rrv64_l1_victim_buf.sv
// rrv64_l1_victim_buf: in-order L1 victim FIFO with drain FSM; refill forwarding lookup enabled by RRV64_VICTIM_FWD_EN
module rrv64_l1_victim_buf
  import rrv64_victim_buf_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int PADDR_W = PADDR_W_DEF,
  parameter int LINE_W  = LINE_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PADDR_W-1:0] in_addr,
  input  logic [LINE_W-1:0]  in_data,
  input  logic               in_dirty,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PADDR_W-1:0] out_addr,
  output logic [LINE_W-1:0]  out_data,
  output logic               out_dirty,
  input  logic               drain_req,
  output logic               drain_done,
  output logic               empty,
  input  logic [PADDR_W-1:0] lkup_addr,
  output logic               lkup_hit,
  output logic [LINE_W-1:0]  lkup_data,
  output logic               lkup_dirty
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  logic [CW-1:0] count;
  logic [PW-1:0] wr_ptr, rd_ptr;
  vb_state_e state, state_nx;
  vb_entry_t wr_e, rd_e;
  logic [DEPTH-1:0] vld;
  logic push, pop;
  assign in_ready   = (count != CW'(DEPTH)) && (state == IDLE);
  assign out_valid  = count != '0;
  assign empty      = count == '0;
  assign drain_done = state == DONE;
  assign push       = in_valid && in_ready;
  assign pop        = out_valid && out_ready;
  assign wr_e       = '{addr: PADDR_W_DEF'(in_addr), data: LINE_W_DEF'(in_data), dirty: in_dirty};
  assign out_addr   = PADDR_W'(rd_e.addr);
  assign out_data   = LINE_W'(rd_e.data);
  assign out_dirty  = rd_e.dirty;
  // drain FSM next state: an empty buffer still spends one cycle in DRAIN
  always_comb begin
    state_nx = (state == IDLE)  ? (drain_req ? DRAIN : IDLE) :
               (state == DRAIN) ? (empty ? DONE : DRAIN) : IDLE;
  end
  // occupancy, pointers and FSM state
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      state  <= IDLE;
    end else begin
      count  <= count + CW'(push) - CW'(pop);
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop);
      state  <= state_nx;
    end
  end
`ifdef RRV64_VICTIM_FWD_EN
  vb_entry_t ents [DEPTH];
  rrv64_victim_buf_mem #(.DEPTH(DEPTH)) u_mem (
    .clk(clk), .rst(rst), .we(push), .waddr(wr_ptr), .wdata(wr_e),
    .re(pop), .raddr(rd_ptr), .rdata(rd_e), .vld(vld), .ents(ents)
  );
  // walk entries oldest to newest so the last match wins as the newest copy
  always_comb begin
    lkup_hit   = 1'b0;
    lkup_data  = '0;
    lkup_dirty = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[rd_ptr + PW'(i)] && ents[rd_ptr + PW'(i)].addr == PADDR_W_DEF'(lkup_addr)) begin
        lkup_hit   = 1'b1;
        lkup_data  = LINE_W'(ents[rd_ptr + PW'(i)].data);
        lkup_dirty = ents[rd_ptr + PW'(i)].dirty;
      end
    end
  end
`else
  logic unused_lkup;
  rrv64_victim_buf_mem #(.DEPTH(DEPTH)) u_mem (
    .clk(clk), .rst(rst), .we(push), .waddr(wr_ptr), .wdata(wr_e),
    .re(pop), .raddr(rd_ptr), .rdata(rd_e), .vld(vld)
  );
  assign lkup_hit    = 1'b0;
  assign lkup_data   = '0;
  assign lkup_dirty  = 1'b0;
  assign unused_lkup = ^{lkup_addr, vld};
`endif
endmodule

// File: tb/tb_rrv64_l1_victim_buf.sv
// tb_rrv64_l1_victim_buf: table vectors, directed corner sequences and random traffic against a queue model
module tb_rrv64_l1_victim_buf;
  localparam int DEPTH = 4;
  localparam int AW = 56;
  localparam int DW = 512;
`ifdef RRV64_VICTIM_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_dirty = 1'b0, out_ready = 1'b0, drain_req = 1'b0;
  logic [AW-1:0] in_addr = '0, lkup_addr = '0;
  logic [DW-1:0] in_data = '0;
  logic in_ready, out_valid, out_dirty, drain_done, empty, lkup_hit, lkup_dirty;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data, lkup_data;
  int vectors = 0, miscompares = 0;
  bit rec = 1'b0;
  logic [AW-1:0] obs [$];
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          y;
  } ment_t;
  ment_t q [$];
  int mst = 0;
  typedef struct {
    bit rst; bit iv; bit [15:0] ad; bit orr; bit dr; bit chk;
    bit eir; bit eov; bit [15:0] ea; bit eem; bit edn;
  } vec_t;
  vec_t tv [14];

  always #5 clk = ~clk;

  rrv64_l1_victim_buf #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .in_data(in_data), .in_dirty(in_dirty), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data), .out_dirty(out_dirty), .drain_req(drain_req),
    .drain_done(drain_done), .empty(empty), .lkup_addr(lkup_addr), .lkup_hit(lkup_hit),
    .lkup_data(lkup_data), .lkup_dirty(lkup_dirty)
  );

  function automatic logic [DW-1:0] dat(logic [AW-1:0] a, int salt);
    return {16{a[31:0] ^ 32'(salt * 32'h9E37_79B9)}};
  endfunction

  function automatic logic [DW-1:0] rnd_line();
    logic [DW-1:0] d;
    for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic chk(string n, logic [DW-1:0] act, logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  task automatic check_model();
    logic eh;
    logic [DW-1:0] ed;
    logic edy;
    eh = 1'b0; ed = '0; edy = 1'b0;
    chk("in_ready", DW'(in_ready), DW'(q.size() != DEPTH && mst == 0));
    chk("out_valid", DW'(out_valid), DW'(q.size() != 0));
    chk("empty", DW'(empty), DW'(q.size() == 0));
    chk("drain_done", DW'(drain_done), DW'(mst == 2));
    if (q.size() != 0) begin
      chk("out_addr", DW'(out_addr), DW'(q[0].a));
      chk("out_data", out_data, q[0].d);
      chk("out_dirty", DW'(out_dirty), DW'(q[0].y));
    end
`ifdef RRV64_VICTIM_FWD_EN
    foreach (q[i]) if (q[i].a == lkup_addr) begin eh = 1'b1; ed = q[i].d; edy = q[i].y; end
`endif
    chk("lkup_hit", DW'(lkup_hit), DW'(eh));
    chk("lkup_data", lkup_data, ed);
    chk("lkup_dirty", DW'(lkup_dirty), DW'(edy));
    if (rec && out_valid && out_ready) obs.push_back(out_addr);
  endtask

  task automatic model_update();
    bit push, pop;
    if (rst) begin
      q.delete();
      mst = 0;
      return;
    end
    push = in_valid && q.size() != DEPTH && mst == 0;
    pop = out_ready && q.size() != 0;
    mst = (mst == 0) ? (drain_req ? 1 : 0) : (mst == 1) ? (q.size() == 0 ? 2 : 1) : 0;
    if (pop) void'(q.pop_front());
    if (push) q.push_back('{a: in_addr, d: in_data, y: in_dirty});
  endtask

  task automatic finish_cycle();
    if (!rst) check_model();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic cycle();
    @(negedge clk);
    finish_cycle();
  endtask

  task automatic push_line(logic [AW-1:0] a, logic [DW-1:0] d, logic y);
    in_valid = 1'b1; in_addr = a; in_data = d; in_dirty = y;
    cycle();
    in_valid = 1'b0;
  endtask

  initial begin
    tv[0]  = '{1, 0, 16'h000, 0, 0, 0, 0, 0, 16'h000, 0, 0};
    tv[1]  = '{0, 1, 16'h100, 0, 0, 1, 1, 0, 16'h000, 1, 0};
    tv[2]  = '{0, 1, 16'h101, 0, 0, 1, 1, 1, 16'h100, 0, 0};
    tv[3]  = '{0, 1, 16'h102, 0, 0, 1, 1, 1, 16'h100, 0, 0};
    tv[4]  = '{0, 1, 16'h103, 0, 0, 1, 1, 1, 16'h100, 0, 0};
    tv[5]  = '{0, 1, 16'h104, 0, 0, 1, 0, 1, 16'h100, 0, 0};
    tv[6]  = '{0, 1, 16'h104, 1, 0, 1, 0, 1, 16'h100, 0, 0};
    tv[7]  = '{0, 0, 16'h000, 0, 0, 1, 1, 1, 16'h101, 0, 0};
    tv[8]  = '{0, 0, 16'h000, 1, 1, 1, 1, 1, 16'h101, 0, 0};
    tv[9]  = '{0, 1, 16'h1F0, 1, 0, 1, 0, 1, 16'h102, 0, 0};
    tv[10] = '{0, 0, 16'h000, 1, 0, 1, 0, 1, 16'h103, 0, 0};
    tv[11] = '{0, 0, 16'h000, 1, 0, 1, 0, 0, 16'h000, 1, 0};
    tv[12] = '{0, 0, 16'h000, 1, 0, 1, 0, 0, 16'h000, 1, 1};
    tv[13] = '{0, 0, 16'h000, 1, 0, 1, 1, 0, 16'h000, 1, 0};
    foreach (tv[i]) begin
      rst = tv[i].rst; in_valid = tv[i].iv; in_addr = AW'(tv[i].ad);
      in_data = dat(AW'(tv[i].ad), 0); in_dirty = tv[i].ad[0];
      out_ready = tv[i].orr; drain_req = tv[i].dr;
      @(negedge clk);
      if (tv[i].chk) begin
        chk($sformatf("tab%0d_in_ready", i), DW'(in_ready), DW'(tv[i].eir));
        chk($sformatf("tab%0d_out_valid", i), DW'(out_valid), DW'(tv[i].eov));
        chk($sformatf("tab%0d_empty", i), DW'(empty), DW'(tv[i].eem));
        chk($sformatf("tab%0d_drain_done", i), DW'(drain_done), DW'(tv[i].edn));
        if (tv[i].eov) chk($sformatf("tab%0d_out_addr", i), DW'(out_addr), DW'(tv[i].ea));
      end
      finish_cycle();
    end
    in_valid = 1'b0; drain_req = 1'b0;

    rec = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) push_line(AW'(i), dat(AW'(i), 3), 1'b0);
    repeat (3) cycle();
    rec = 1'b0;
    chk("wrap_count", DW'(obs.size()), DW'(10));
    for (int k = 0; k < 10; k++) chk($sformatf("wrap_order%0d", k), DW'(k < obs.size() ? obs[k] : '1), DW'(k));

    out_ready = 1'b0;
    push_line(AW'('h10), dat(AW'('h10), 4), 1'b1);
    push_line(AW'('h11), dat(AW'('h11), 4), 1'b0);
    drain_req = 1'b1; cycle(); drain_req = 1'b0;
    cycle();
    rst = 1'b1; cycle(); rst = 1'b0;
    @(negedge clk);
    chk("rstdrain_empty", DW'(empty), DW'(1));
    chk("rstdrain_in_ready", DW'(in_ready), DW'(1));
    chk("rstdrain_drain_done", DW'(drain_done), DW'(0));
    chk("rstdrain_out_valid", DW'(out_valid), DW'(0));
    finish_cycle();
    repeat (3) cycle();

    push_line(AW'('h200), dat(AW'('h200), 1), 1'b0);
    push_line(AW'('h200), dat(AW'('h200), 2), 1'b1);
    lkup_addr = AW'('h200);
    @(negedge clk);
    chk("fwd_hit", DW'(lkup_hit), DW'(FWD));
    chk("fwd_data", lkup_data, FWD ? dat(AW'('h200), 2) : '0);
    chk("fwd_dirty", DW'(lkup_dirty), DW'(FWD));
    finish_cycle();
    lkup_addr = AW'('h300);
    @(negedge clk);
    chk("fwd_miss", DW'(lkup_hit), DW'(0));
    finish_cycle();
    out_ready = 1'b1;
    repeat (3) cycle();

    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      in_valid = $urandom_range(0, 1);
      in_addr = AW'(32'h200 + $urandom_range(0, 7));
      in_data = rnd_line();
      in_dirty = $urandom_range(0, 1);
      out_ready = ($urandom_range(0, 9) < 6);
      drain_req = ($urandom_range(0, 29) == 0);
      lkup_addr = AW'(32'h200 + $urandom_range(0, 7));
      cycle();
    end
    rst = 1'b0; in_valid = 1'b0; drain_req = 1'b0;
    repeat (2) cycle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
